// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector
//   Programmable serial pattern detector for a qualified bit stream, such as
//   the output of a deserialiser or UART receiver. It matches a runtime-loaded
//   PAT_W-bit pattern in overlapping or non-overlapping mode. Each occurrence
//   produces a one-cycle registered pulse, and a saturating counter records
//   the number of occurrences.
//
// Parameters
//   PAT_W        pattern length in bits (2..16)
//   CNT_W        match counter width (1..32)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; restores the power-on config
//                (PAT_W ones, overlapping)
//   in_valid     x is accepted only when high
//   x            serial data bit
//   cfg_load     latches cfg_pattern/cfg_overlap and restarts detection; an
//                in_valid bit on the same cycle is dropped
//   cfg_pattern  pattern to match; bit PAT_W-1 is the first bit received
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   y            registered match pulse, one cycle after the completing bit
//   match_count  matches since reset/cfg_load, saturating at all-ones
//   count_sat    high while match_count is all-ones
module seq_pattern_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             x,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  // FILLING: fewer than PAT_W fresh bits seen; ARMED: history fully valid.
  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [PAT_W-1:0]   history, history_next;
  logic [FILL_W-1:0]  fill, fill_next;
  logic [PAT_W-1:0]   pattern, pattern_next;
  logic               overlap, overlap_next;
  logic               y_next;
  logic [CNT_W-1:0]   count_next;
  logic               sat_next;

  logic [PAT_W-1:0]   hist_acc;
  logic [FILL_W-1:0]  fill_acc;
  logic               hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILLING;
      history     <= '0;
      fill        <= '0;
      pattern     <= '1;
      overlap     <= 1'b1;
      y           <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      state       <= state_next;
      history     <= history_next;
      fill        <= fill_next;
      pattern     <= pattern_next;
      overlap     <= overlap_next;
      y           <= y_next;
      match_count <= count_next;
      count_sat   <= sat_next;
    end
  end

  always_comb begin
    history_next = history;
    fill_next    = fill;
    pattern_next = pattern;
    overlap_next = overlap;
    y_next       = 1'b0;
    count_next   = match_count;

    // Candidate values if the current bit is accepted; the match is judged
    // on the post-shift history so y lines up with the completing bit.
    hist_acc = {history[PAT_W-2:0], x};
    fill_acc = (state == ARMED) ? FILL_FULL : fill + FILL_W'(1);
    hit      = (fill_acc == FILL_FULL) && (hist_acc == pattern);

    if (cfg_load) begin
      pattern_next = cfg_pattern;
      overlap_next = cfg_overlap;
      history_next = '0;
      fill_next    = '0;
      count_next   = '0;
    end else if (in_valid) begin
      history_next = hist_acc;
      // Non-overlapping mode forgets the matched bits so the next hit needs
      // PAT_W fresh ones; history contents are then irrelevant until refilled.
      fill_next    = (hit && !overlap) ? '0 : fill_acc;
      y_next       = hit;
      if (hit && (match_count != CNT_MAX)) begin
        count_next = match_count + CNT_W'(1);
      end
    end

    sat_next   = (count_next == CNT_MAX);
    state_next = (fill_next == FILL_FULL) ? ARMED : FILLING;
  end

endmodule
